riscv_ahb3lite_arb: RTL



---
 rtl/riscv_ahb3lite_arb_pkg.sv | 23 ++
 rtl/riscv_ahb3lite_arb_if.sv | 48 ++++
 rtl/riscv_ahb3lite_arb_rr.sv | 103 ++++++++++
 rtl/riscv_ahb3lite_arb.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/riscv_ahb3lite_arb_pkg.sv
// Shared AHB3-Lite encodings and helpers for the N-channel master arbiter.
package riscv_ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // Channel index width; a single channel still needs one bit to index.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_ahb3lite_arb_if.sv
// Channel request/response and AHB3-Lite master signals of the arbiter.
// master: the arbiter itself; slave: the request channels plus the AHB slave side.
interface riscv_ahb3lite_arb_if #(
  parameter int CHANNELS       = 2,
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN
);

  logic [CHANNELS-1:0]                     ch_req;
  logic [CHANNELS-1:0][PHYS_ADDR_SIZE-1:0] ch_adr;
  logic [CHANNELS-1:0]                     ch_we;
  logic [CHANNELS-1:0][2:0]                ch_size;
  logic [CHANNELS-1:0][3:0]                ch_prot;
  logic [CHANNELS-1:0][XLEN-1:0]           ch_d;
  logic [CHANNELS-1:0]                     ch_lock;
  logic [CHANNELS-1:0]                     ch_gnt;
  logic [CHANNELS-1:0]                     ch_ack;
  logic [CHANNELS-1:0]                     ch_err;
  logic [XLEN-1:0]                         ch_q;

  logic                      HSEL;
  logic [PHYS_ADDR_SIZE-1:0] HADDR;
  logic [XLEN-1:0]           HWDATA;
  logic                      HWRITE;
  logic [2:0]                HSIZE;
  logic [2:0]                HBURST;
  logic [3:0]                HPROT;
  logic [1:0]                HTRANS;
  logic                      HMASTLOCK;
  logic [XLEN-1:0]           HRDATA;
  logic                      HREADY;
  logic                      HRESP;

  modport master (
    input  ch_req, ch_adr, ch_we, ch_size, ch_prot, ch_d, ch_lock,
    output ch_gnt, ch_ack, ch_err, ch_q,
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output ch_req, ch_adr, ch_we, ch_size, ch_prot, ch_d, ch_lock,
    input  ch_gnt, ch_ack, ch_err, ch_q,
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/riscv_ahb3lite_arb_rr.sv
// Channel arbiter: fixed priority or round-robin, one-hot winner, pointer moves on grant.
// RISCV_AHB_ARB_LOCK_EN adds locked-sequence ownership that overrides normal priority.
module riscv_ahb3lite_arb_rr
  import riscv_ahb3lite_pkg::*;
#(
  parameter int  CHANNELS = 2,
  parameter int  ARB_RR   = 0,
  localparam int CHW      = ch_idx_w(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] req_i,
  input  logic [CHANNELS-1:0] lock_i,
  input  logic                strobe_i,
  output logic [CHANNELS-1:0] win_o,
  output logic [CHW-1:0]      win_idx_o,
  output logic                locked_o
);

  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] base;
  logic [CHW-1:0] rr_idx;
  logic           rr_found;
  logic [CHW:0]   cand;
  logic           hold;
  logic [CHW-1:0] hold_ch;

  // Search upward from the base index, wrapping at CHANNELS.
  always_comb begin
    base     = (ARB_RR != 0) ? ptr_q : '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = {1'b0, base} + (CHW+1)'(i);
      if (cand >= (CHW+1)'(CHANNELS)) cand = cand - (CHW+1)'(CHANNELS);
      if (!rr_found && req_i[cand[CHW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[CHW-1:0];
      end
    end
  end

`ifdef RISCV_AHB_ARB_LOCK_EN
  logic           locked_q, locked_d;
  logic [CHW-1:0] lock_ch_q, lock_ch_d;

  assign hold     = locked_q & req_i[lock_ch_q];
  assign hold_ch  = lock_ch_q;
  // The releasing transfer (ch_lock low) is still part of the locked sequence.
  assign locked_o = lock_i[win_idx_o] | hold;

  always_comb begin
    locked_d  = locked_q;
    lock_ch_d = lock_ch_q;
    if (locked_q && !req_i[lock_ch_q]) locked_d = 1'b0;
    if (strobe_i) begin
      if (lock_i[win_idx_o]) begin
        locked_d  = 1'b1;
        lock_ch_d = win_idx_o;
      end else if (hold) begin
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      locked_q  <= locked_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  logic unused_lock;

  assign hold        = 1'b0;
  assign hold_ch     = '0;
  assign locked_o    = 1'b0;
  assign unused_lock = ^lock_i;
`endif

  always_comb begin
    win_idx_o = hold ? hold_ch : rr_idx;
    win_o     = '0;
    if (hold || rr_found) win_o[win_idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if ((ARB_RR != 0) && strobe_i) begin
      ptr_d = (win_idx_o == CHW'(CHANNELS-1)) ? '0 : win_idx_o + CHW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/riscv_ahb3lite_arb.sv
// N-channel pipelined AHB3-Lite master: arbitrated address phase overlapping the data phase.
// RISCV_AHB_ARB_LOCK_EN enables locked sequences and drives HMASTLOCK; otherwise HMASTLOCK is 0.
module riscv_ahb3lite_arb
  import riscv_ahb3lite_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN,
  parameter int ARB_RR         = 0
) (
  input logic                  HCLK,
  input logic                  HRESET,
  riscv_ahb3lite_arb_if.master bus
);

  localparam int CHW = ch_idx_w(CHANNELS);

  logic                      ap_valid_q, ap_valid_d;
  logic [CHW-1:0]            ap_ch_q, ap_ch_d;
  logic [PHYS_ADDR_SIZE-1:0] ap_adr_q, ap_adr_d;
  logic                      ap_we_q, ap_we_d;
  logic [2:0]                ap_size_q, ap_size_d;
  logic [3:0]                ap_prot_q, ap_prot_d;
  logic                      ap_lock_q, ap_lock_d;
  logic                      dp_valid_q, dp_valid_d;
  logic [CHW-1:0]            dp_ch_q, dp_ch_d;
  logic                      dp_we_q, dp_we_d;
  logic                      err_hold_q, err_hold_d;

  logic                      load_en;
  logic                      strobe;
  logic                      ap_live;
  logic [CHANNELS-1:0]       win;
  logic [CHW-1:0]            win_idx;
  logic                      win_lock;

  // Gating with HRESET keeps ch_gnt at its reset value while reset is asserted.
  assign load_en = (!ap_valid_q | bus.HREADY) & !err_hold_q & !HRESET;
  assign strobe  = load_en & (|bus.ch_req);
  assign ap_live = ap_valid_q & !err_hold_q;

  riscv_ahb3lite_arb_rr #(
    .CHANNELS (CHANNELS),
    .ARB_RR   (ARB_RR)
  ) u_arb (
    .clk_i     (HCLK),
    .rst_i     (HRESET),
    .req_i     (bus.ch_req),
    .lock_i    (bus.ch_lock),
    .strobe_i  (strobe),
    .win_o     (win),
    .win_idx_o (win_idx),
    .locked_o  (win_lock)
  );

  assign bus.ch_gnt = win & {CHANNELS{load_en}};

  always_comb begin
    ap_valid_d = ap_valid_q;
    ap_ch_d    = ap_ch_q;
    ap_adr_d   = ap_adr_q;
    ap_we_d    = ap_we_q;
    ap_size_d  = ap_size_q;
    ap_prot_d  = ap_prot_q;
    ap_lock_d  = ap_lock_q;
    dp_valid_d = dp_valid_q;
    dp_ch_d    = dp_ch_q;
    dp_we_d    = dp_we_q;

    if (load_en) begin
      ap_valid_d = |bus.ch_req;
      if (|bus.ch_req) begin
        ap_ch_d   = win_idx;
        ap_adr_d  = bus.ch_adr[win_idx];
        ap_we_d   = bus.ch_we[win_idx];
        ap_size_d = bus.ch_size[win_idx];
        ap_prot_d = bus.ch_prot[win_idx];
        ap_lock_d = win_lock;
      end
    end

    // A held (cancelled) address phase never advances; dp simply drains.
    if (bus.HREADY) begin
      dp_valid_d = ap_live;
      dp_ch_d    = ap_ch_q;
      dp_we_d    = ap_we_q;
    end

    err_hold_d = err_hold_q ? !bus.HREADY
                            : (dp_valid_q & bus.HRESP & !bus.HREADY);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_valid_q <= 1'b0;
      ap_ch_q    <= '0;
      ap_adr_q   <= '0;
      ap_we_q    <= 1'b0;
      ap_size_q  <= '0;
      ap_prot_q  <= '0;
      ap_lock_q  <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_ch_q    <= '0;
      dp_we_q    <= 1'b0;
      err_hold_q <= 1'b0;
    end else begin
      ap_valid_q <= ap_valid_d;
      ap_ch_q    <= ap_ch_d;
      ap_adr_q   <= ap_adr_d;
      ap_we_q    <= ap_we_d;
      ap_size_q  <= ap_size_d;
      ap_prot_q  <= ap_prot_d;
      ap_lock_q  <= ap_lock_d;
      dp_valid_q <= dp_valid_d;
      dp_ch_q    <= dp_ch_d;
      dp_we_q    <= dp_we_d;
      err_hold_q <= err_hold_d;
    end
  end

  assign bus.HSEL   = ap_live;
  assign bus.HTRANS = ap_live ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR  = ap_adr_q;
  assign bus.HWRITE = ap_we_q;
  assign bus.HSIZE  = ap_size_q;
  assign bus.HPROT  = ap_prot_q;
  assign bus.HBURST = HBURST_SINGLE;
  assign bus.HWDATA = (dp_valid_q & dp_we_q) ? bus.ch_d[dp_ch_q] : '0;
  assign bus.ch_q   = bus.HRDATA;

`ifdef RISCV_AHB_ARB_LOCK_EN
  assign bus.HMASTLOCK = ap_lock_q;
`else
  logic unused_ap_lock;

  assign bus.HMASTLOCK  = 1'b0;
  assign unused_ap_lock = ap_lock_q;
`endif

  always_comb begin
    bus.ch_ack = '0;
    bus.ch_err = '0;
    if (dp_valid_q && bus.HREADY) begin
      if (bus.HRESP) bus.ch_err[dp_ch_q] = 1'b1;
      else           bus.ch_ack[dp_ch_q] = 1'b1;
    end
  end

endmodule
